// File: rtl/score_pkg.sv
// ============================================================================
// score_pkg : shared BCD types and helpers for the score accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

package score_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

   // Inputs above 99 are outside the supported point range.
   function automatic logic [7:0] bin_to_bcd2(input logic [7:0] bin);
      bcd_digit_t tens;
      bcd_digit_t ones;
      tens = 4'(bin / 8'd10);
      ones = 4'(bin % 8'd10);
      return {tens, ones};
   endfunction

   // Packed BCD with the most significant digit in the MSBs orders like unsigned binary.
   function automatic logic bcd_gt(input logic [31:0] a, input logic [31:0] b);
      return a > b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_adder.sv
// ============================================================================
// bcd_adder : combinational DIGITS-wide ripple BCD adder with carry out
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_adder #(
   parameter int DIGITS = 4
) (
   input  logic [4*DIGITS-1:0] a_i,
   input  logic [4*DIGITS-1:0] b_i,
   output logic [4*DIGITS-1:0] sum_o,
   output logic                carry_o
);

   logic [DIGITS:0] w_carry;

   assign w_carry[0] = 1'b0;

   generate
      for (genvar g = 0; g < DIGITS; g++) begin : g_digit
         logic [4:0] w_raw;
         assign w_raw = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]} + {4'd0, w_carry[g]};
         // A digit sum above 9 wraps into the next digit after the +6 correction.
         assign w_carry[g+1]   = (w_raw > 5'd9);
         assign sum_o[4*g +: 4] = w_carry[g+1] ? 4'(w_raw + 5'd6) : w_raw[3:0];
      end
   endgenerate

   assign carry_o = w_carry[DIGITS];

endmodule

`default_nettype wire

// File: rtl/score_accumulator.sv
// ============================================================================
// score_accumulator : per-channel point slots, round-robin drain, saturating
//                     BCD score and high score. DIGITS must be at least 2.
// Rev 1.0
// ============================================================================
`default_nettype none

module score_accumulator
   import score_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int PTS_W  = 4,
   parameter int DIGITS = 4
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    clear_score,
   input  logic [N_CH-1:0]         pt_valid,
   input  logic [N_CH*PTS_W-1:0]   pt_value,
   output logic [4*DIGITS-1:0]     score_bcd,
   output logic [4*DIGITS-1:0]     high_bcd,
   output logic [N_CH-1:0]         pending,
   output logic                    lost,
   output logic                    saturated
);

   localparam int RR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int RRX_W = RR_W + 1;
   localparam int SW    = 4 * DIGITS;
   localparam logic [SW-1:0] C_SCORE_MAX = {DIGITS{BCD_MAX_DIGIT}};

   logic [PTS_W-1:0] slot_val_q [N_CH];
   logic [PTS_W-1:0] slot_val_d [N_CH];
   logic [N_CH-1:0]  pending_q, pending_d;
   logic [RR_W-1:0]  rr_q, rr_d;
   logic             lost_q, lost_d;
   logic [PTS_W-1:0] add_val_q;
   logic             add_vld_q;
   logic [SW-1:0]    score_q;
   logic [SW-1:0]    high_q;
   logic             sat_q;

   logic             w_grant_vld;
   logic [RR_W-1:0]  w_grant_idx;
   logic [N_CH-1:0]  w_grant_oh;
   logic [SW-1:0]    w_add_bcd;
   logic [SW-1:0]    w_sum_bcd;
   logic             w_carry;
   logic [SW-1:0]    w_score_new;

   // Search starts at rr and wraps, so the first hit is the round-robin winner.
   always_comb begin
      logic [RRX_W-1:0] cand;
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      for (int k = 0; k < N_CH; k++) begin
         cand = {1'b0, rr_q} + RRX_W'(k);
         if (cand >= RRX_W'(N_CH)) begin
            cand = cand - RRX_W'(N_CH);
         end
         if (!w_grant_vld && pending_q[cand[RR_W-1:0]]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = cand[RR_W-1:0];
         end
      end
   end

   assign w_grant_oh = w_grant_vld ? (N_CH'(1) << w_grant_idx) : '0;

   always_comb begin
      rr_d = rr_q;
      if (w_grant_vld) begin
         rr_d = (w_grant_idx == RR_W'(N_CH - 1)) ? '0 : w_grant_idx + RR_W'(1);
      end
   end

   // A slot drained this cycle may accept a fresh event without loss.
   always_comb begin
      pending_d  = pending_q;
      slot_val_d = slot_val_q;
      lost_d     = lost_q;
      for (int i = 0; i < N_CH; i++) begin
         if (pt_valid[i]) begin
            if (!pending_q[i] || w_grant_oh[i]) begin
               slot_val_d[i] = pt_value[i*PTS_W +: PTS_W];
               pending_d[i]  = 1'b1;
            end else begin
               lost_d = 1'b1;
            end
         end else if (w_grant_oh[i]) begin
            pending_d[i] = 1'b0;
         end
      end
   end

   assign w_add_bcd = {{(SW-8){1'b0}}, bin_to_bcd2(8'(add_val_q))};

   bcd_adder #(
      .DIGITS (DIGITS)
   ) u_bcd_adder (
      .a_i     (score_q),
      .b_i     (w_add_bcd),
      .sum_o   (w_sum_bcd),
      .carry_o (w_carry)
   );

   assign w_score_new = w_carry ? C_SCORE_MAX : w_sum_bcd;

   always_ff @(posedge Clk) begin
      if (Reset || clear_score) begin
         for (int i = 0; i < N_CH; i++) begin
            slot_val_q[i] <= '0;
         end
         pending_q <= '0;
         rr_q      <= '0;
         lost_q    <= 1'b0;
         add_val_q <= '0;
         add_vld_q <= 1'b0;
         score_q   <= '0;
         sat_q     <= 1'b0;
      end else begin
         slot_val_q <= slot_val_d;
         pending_q  <= pending_d;
         rr_q       <= rr_d;
         lost_q     <= lost_d;
         add_vld_q  <= w_grant_vld;
         add_val_q  <= slot_val_q[w_grant_idx];
         if (add_vld_q) begin
            score_q <= w_score_new;
            if (w_carry) begin
               sat_q <= 1'b1;
            end
         end
      end
   end

   // High score survives clear_score; only Reset zeroes it.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         high_q <= '0;
      end else if (!clear_score && add_vld_q && bcd_gt(32'(w_score_new), 32'(high_q))) begin
         high_q <= w_score_new;
      end
   end

   assign score_bcd = score_q;
   assign high_bcd  = high_q;
   assign pending   = pending_q;
   assign lost      = lost_q;
   assign saturated = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_score_accumulator.sv
// ============================================================================
// tb_score_accumulator : directed self-checking bench for score_accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_score_accumulator;

   localparam int N_CH   = 4;
   localparam int PTS_W  = 4;
   localparam int DIGITS = 4;

   logic                  Clk = 1'b0;
   logic                  Reset;
   logic                  clear_score;
   logic [N_CH-1:0]       pt_valid;
   logic [N_CH*PTS_W-1:0] pt_value;
   logic [4*DIGITS-1:0]   score_bcd;
   logic [4*DIGITS-1:0]   high_bcd;
   logic [N_CH-1:0]       pending;
   logic                  lost;
   logic                  saturated;

   int n_checks = 0;
   int n_errors = 0;

   score_accumulator #(
      .N_CH   (N_CH),
      .PTS_W  (PTS_W),
      .DIGITS (DIGITS)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .clear_score (clear_score),
      .pt_valid    (pt_valid),
      .pt_value    (pt_value),
      .score_bcd   (score_bcd),
      .high_bcd    (high_bcd),
      .pending     (pending),
      .lost        (lost),
      .saturated   (saturated)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic [N_CH-1:0] v, input logic [N_CH*PTS_W-1:0] val);
      pt_valid = v;
      pt_value = val;
      tick();
      pt_valid = '0;
   endtask

   task automatic do_reset();
      Reset       = 1'b1;
      clear_score = 1'b0;
      pt_valid    = '0;
      pt_value    = '0;
      tick();
      tick();
      Reset = 1'b0;
   endtask

   initial begin
      logic [3:0]  exp_pend [5];
      logic [15:0] exp_score[5];
      logic [15:0] rr_score [6];

      do_reset();
      check("rst_score", 32'(score_bcd), 32'h0);
      check("rst_high", 32'(high_bcd), 32'h0);
      check("rst_pending", 32'(pending), 32'h0);
      check("rst_lost", 32'(lost), 32'h0);
      check("rst_sat", 32'(saturated), 32'h0);

      // Single event on ch2
      drive(4'b0100, 16'h0500);
      check("single_pend1", 32'(pending), 32'h4);
      tick();
      check("single_pend2", 32'(pending), 32'h0);
      check("single_score_early", 32'(score_bcd), 32'h0);
      tick();
      check("single_score", 32'(score_bcd), 32'h5);
      check("single_high", 32'(high_bcd), 32'h5);

      // Simultaneous events on all channels, drained 0,1,2,3
      do_reset();
      drive(4'b1111, 16'h4321);
      check("simul_pend0", 32'(pending), 32'hF);
      exp_pend  = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
      exp_score = '{16'h0000, 16'h0001, 16'h0003, 16'h0006, 16'h0010};
      for (int i = 0; i < 5; i++) begin
         tick();
         check("simul_pend", 32'(pending), 32'(exp_pend[i]));
         check("simul_score", 32'(score_bcd), 32'(exp_score[i]));
      end
      check("simul_lost", 32'(lost), 32'h0);

      // Second ch1 event while its slot is still full
      do_reset();
      drive(4'b0011, 16'h0073);
      check("ovf_pend0", 32'(pending), 32'h3);
      drive(4'b0010, 16'h0080);
      check("ovf_lost", 32'(lost), 32'h1);
      check("ovf_pend1", 32'(pending), 32'h2);
      tick();
      check("ovf_score1", 32'(score_bcd), 32'h3);
      tick();
      check("ovf_score2", 32'(score_bcd), 32'h10);
      check("ovf_pend2", 32'(pending), 32'h0);

      // Saturation: 666*15 + 5 = 9995, then +9 clamps
      do_reset();
      for (int i = 0; i < 666; i++) begin
         drive(4'b0001, 16'h000F);
      end
      drive(4'b0001, 16'h0005);
      tick();
      tick();
      check("sat_pre_score", 32'(score_bcd), 32'h9995);
      check("sat_pre_flag", 32'(saturated), 32'h0);
      check("sat_sustain_lost", 32'(lost), 32'h0);
      drive(4'b0001, 16'h0009);
      tick();
      tick();
      check("sat_score", 32'(score_bcd), 32'h9999);
      check("sat_flag", 32'(saturated), 32'h1);
      check("sat_high", 32'(high_bcd), 32'h9999);
      drive(4'b0001, 16'h000F);
      tick();
      tick();
      check("sat_hold", 32'(score_bcd), 32'h9999);

      // Build 42, create a loss with zero-value events, then clear
      do_reset();
      drive(4'b0001, 16'h000F);
      drive(4'b0001, 16'h000F);
      drive(4'b0001, 16'h000C);
      tick();
      tick();
      check("clr_score42", 32'(score_bcd), 32'h42);
      drive(4'b0110, 16'h0000);
      drive(4'b0100, 16'h0000);
      check("clr_lost_set", 32'(lost), 32'h1);
      tick();
      tick();
      tick();
      check("zero_val_score", 32'(score_bcd), 32'h42);
      clear_score = 1'b1;
      pt_valid    = 4'b1000;
      pt_value    = 16'h5000;
      tick();
      clear_score = 1'b0;
      pt_valid    = '0;
      check("clr_score", 32'(score_bcd), 32'h0);
      check("clr_pend", 32'(pending), 32'h0);
      check("clr_lost", 32'(lost), 32'h0);
      check("clr_high", 32'(high_bcd), 32'h42);
      tick();
      check("clr_pend_after", 32'(pending), 32'h0);
      check("clr_score_after", 32'(score_bcd), 32'h0);
      do_reset();
      check("rst_high_clr", 32'(high_bcd), 32'h0);

      // Round robin between ch0 (value 1) and ch3 (value 4)
      do_reset();
      drive(4'b1001, 16'h4001);
      drive(4'b0001, 16'h4001);
      rr_score = '{16'h0001, 16'h0005, 16'h0006, 16'h0010, 16'h0011, 16'h0015};
      drive(4'b1000, 16'h4001);
      check("rr_score0", 32'(score_bcd), 32'(rr_score[0]));
      drive(4'b0001, 16'h4001);
      check("rr_score1", 32'(score_bcd), 32'(rr_score[1]));
      drive(4'b1000, 16'h4001);
      check("rr_score2", 32'(score_bcd), 32'(rr_score[2]));
      for (int i = 3; i < 6; i++) begin
         tick();
         check("rr_score", 32'(score_bcd), 32'(rr_score[i]));
      end
      check("rr_lost", 32'(lost), 32'h0);
      check("rr_pend", 32'(pending), 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
